// File: rtl/ranger_pkg.sv
// Shared types, 50 MHz defaults and width helper for the multi-channel ultrasonic ranger.
package ranger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_DONE      = 3'd4,
        ST_HOLD      = 3'd5
    } state_e;

    localparam int DEF_N_CH        = 2;
    localparam int DEF_DIGITS      = 4;
    localparam int DEF_TICK_DIV    = 2942;
    localparam int DEF_TRIG_CYC    = 501;
    localparam int DEF_SLOT_CYC    = 12_500_000;
    localparam int DEF_TIMEOUT_CYC = 1_500_000;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        while ((longint'(1) << r) < longint'(v)) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_mc_bcd_acc.sv
// Packed BCD up-counter with single-cycle ripple carry, synchronous clear and saturation at all 9s.
module bcd_acc #(
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [DIGITS*4-1:0]   q_o,
    output logic [DIGITS*4-1:0]   nxt_o,
    output logic                  sat_o
);

    localparam int DW = DIGITS * 4;

    logic [DW-1:0] q_q, q_d;
    logic          sat;
    logic          carry;

    always_comb begin
        sat = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (q_q[i*4 +: 4] != 4'd9) sat = 1'b0;
        end
        q_d   = q_q;
        carry = inc_i & ~sat;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (q_q[i*4 +: 4] == 4'd9) begin
                    q_d[i*4 +: 4] = 4'd0;
                end else begin
                    q_d[i*4 +: 4] = q_q[i*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        if (clr_i) q_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q_o   = q_q;
    assign nxt_o = q_d;
    assign sat_o = sat;

endmodule

// File: rtl/ultrasonic_ranger_mc.sv
// Round-robin HC-SR04 ranging engine: fires one channel per slot, times its echo and
// publishes a packed-BCD distance (or all 9s on timeout) with a per-channel valid strobe.
module ultrasonic_ranger_mc
    import ranger_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int DIGITS      = DEF_DIGITS,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int TRIG_CYC    = DEF_TRIG_CYC,
    parameter int SLOT_CYC    = DEF_SLOT_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                     sys_clk50m,
    input  logic                     sys_rst,
    input  logic                     en,
    input  logic [N_CH-1:0]          echo,
    output logic [N_CH-1:0]          trig,
    output logic [N_CH*DIGITS*4-1:0] data,
    output logic [N_CH-1:0]          valid,
    output logic [N_CH-1:0]          tmo
);

    localparam int DW     = DIGITS * 4;
    localparam int CH_W   = clog2(N_CH);
    localparam int SLOT_W = clog2(SLOT_CYC);
    localparam int TMR_W  = clog2((TIMEOUT_CYC > TRIG_CYC) ? TIMEOUT_CYC : TRIG_CYC);
    localparam int TICK_W = clog2(TICK_DIV);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYC - 1);
    // HOLD releases one cycle early so the IDLE cycle closes the slot and the period stays exact.
    localparam logic [SLOT_W-1:0] HOLD_END  = SLOT_W'(SLOT_CYC - 2);
    localparam logic [TMR_W-1:0]  TRIG_LAST = TMR_W'(TRIG_CYC - 1);
    localparam logic [TMR_W-1:0]  TMO_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    function automatic logic [DW-1:0] all_nines();
        logic [DW-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[i*4 +: 4] = 4'd9;
        return v;
    endfunction

    localparam logic [DW-1:0] NINES = all_nines();

    logic [N_CH-1:0]      echo_s1_q, echo_s2_q, echo_h_q;
    state_e               state_q, state_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [TICK_W-1:0]    presc_q, presc_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [N_CH-1:0]      trig_q, trig_d;
    logic [N_CH*DW-1:0]   data_q, data_d;
    logic [N_CH-1:0]      valid_q, valid_d;
    logic [N_CH-1:0]      tmo_q, tmo_d;
    logic                 rise, fall, tick;
    logic                 acc_clr, acc_inc, acc_sat;
    logic [DW-1:0]        acc_q, acc_nxt;
    logic                 res_en, res_tmo;
    logic [DW-1:0]        res_val;

    assign rise = echo_s2_q[ch_q] & ~echo_h_q[ch_q];
    assign fall = ~echo_s2_q[ch_q] & echo_h_q[ch_q];
    assign tick = (presc_q == TICK_LAST);

    bcd_acc #(.DIGITS(DIGITS)) u_acc (
        .clk_i (sys_clk50m),
        .rst_i (sys_rst),
        .clr_i (acc_clr),
        .inc_i (acc_inc),
        .q_o   (acc_q),
        .nxt_o (acc_nxt),
        .sat_o (acc_sat)
    );

    always_comb begin
        state_d = state_q;
        slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        tmr_d   = tmr_q + 1'b1;
        presc_d = presc_q;
        ch_d    = ch_q;
        trig_d  = '0;
        acc_clr = 1'b0;
        acc_inc = 1'b0;
        res_en  = 1'b0;
        res_val = NINES;
        res_tmo = 1'b1;
        valid_d = '0;
        data_d  = data_q;
        tmo_d   = tmo_q;

        case (state_q)
            ST_IDLE: begin
                slot_d = slot_q;
                tmr_d  = '0;
                if (en) begin
                    state_d = ST_TRIG;
                    slot_d  = '0;
                end
            end
            ST_TRIG: begin
                trig_d[ch_q] = 1'b1;
                if (tmr_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    tmr_d   = '0;
                end
            end
            ST_WAIT_RISE: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                    tmr_d   = '0;
                    presc_d = '0;
                    acc_clr = 1'b1;
                end else if (tmr_q == TMO_LAST) begin
                    state_d = ST_DONE;
                    res_en  = 1'b1;
                end
            end
            ST_MEASURE: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                acc_inc = tick & ~acc_sat;
                // A fall beats a same-cycle timeout and still counts a same-cycle tick.
                if (fall) begin
                    state_d = ST_DONE;
                    res_en  = 1'b1;
                    res_val = tick ? acc_nxt : acc_q;
                    res_tmo = 1'b0;
                end else if (tmr_q == TMO_LAST) begin
                    state_d = ST_DONE;
                    res_en  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (slot_q == HOLD_END) begin
                    state_d = ST_IDLE;
                    ch_d    = (int'(ch_q) == N_CH - 1) ? '0 : ch_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (res_en) begin
            data_d[int'(ch_q)*DW +: DW] = res_val;
            tmo_d[ch_q]                 = res_tmo;
            valid_d[ch_q]               = 1'b1;
        end
    end

    always_ff @(posedge sys_clk50m) begin
        if (sys_rst) begin
            echo_s1_q <= '0;
            echo_s2_q <= '0;
            echo_h_q  <= '0;
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            tmr_q     <= '0;
            presc_q   <= '0;
            ch_q      <= '0;
            trig_q    <= '0;
            data_q    <= '0;
            valid_q   <= '0;
            tmo_q     <= '0;
        end else begin
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
            echo_h_q  <= echo_s2_q;
            state_q   <= state_d;
            slot_q    <= slot_d;
            tmr_q     <= tmr_d;
            presc_q   <= presc_d;
            ch_q      <= ch_d;
            trig_q    <= trig_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            tmo_q     <= tmo_d;
        end
    end

    assign trig  = trig_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign tmo   = tmo_q;

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Scoreboard bench for ultrasonic_ranger_mc with time constants scaled down (TICK_DIV = 4).
module tb_ultrasonic_ranger_mc;

    localparam int TICK  = 4;
    localparam int TRIGC = 5;
    localparam int TMO   = 1300;
    localparam int SLOT  = 2700;

    typedef struct {
        int          ch;
        logic [15:0] d;
        logic        t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, en, en2;
    logic [1:0]  echo, echo2, trig, trig2, valid, valid2, tmo, tmo2;
    logic [31:0] data;
    logic [15:0] data2;

    exp_t q1[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    ultrasonic_ranger_mc #(
        .N_CH(2), .DIGITS(4), .TICK_DIV(TICK), .TRIG_CYC(TRIGC),
        .SLOT_CYC(SLOT), .TIMEOUT_CYC(TMO)
    ) dut (
        .sys_clk50m(clk), .sys_rst(rst), .en(en), .echo(echo),
        .trig(trig), .data(data), .valid(valid), .tmo(tmo)
    );

    ultrasonic_ranger_mc #(
        .N_CH(2), .DIGITS(2), .TICK_DIV(TICK), .TRIG_CYC(TRIGC),
        .SLOT_CYC(SLOT), .TIMEOUT_CYC(TMO)
    ) dut2 (
        .sys_clk50m(clk), .sys_rst(rst), .en(en2), .echo(echo2),
        .trig(trig2), .data(data2), .valid(valid2), .tmo(tmo2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [31:0] m_data = '0;
    logic [1:0]  m_tmo  = '0;
    always @(negedge clk) begin
        if (rst) begin
            m_data = '0;
            m_tmo  = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (valid[k]) begin
                    if (q1.size() == 0) begin
                        check("dut unexpected valid", 32'(k + 1), 32'd0);
                    end else begin
                        exp_t e;
                        e = q1.pop_front();
                        check("dut result channel", 32'(k), 32'(e.ch));
                        m_data[k*16 +: 16] = e.d;
                        m_tmo[k]           = e.t;
                        check("dut data word", data, m_data);
                        check("dut tmo flags", {30'd0, tmo}, {30'd0, m_tmo});
                    end
                end
            end
        end
    end

    logic [15:0] m_data2 = '0;
    logic [1:0]  m_tmo2  = '0;
    always @(negedge clk) begin
        if (rst) begin
            m_data2 = '0;
            m_tmo2  = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (valid2[k]) begin
                    if (q2.size() == 0) begin
                        check("dut2 unexpected valid", 32'(k + 1), 32'd0);
                    end else begin
                        exp_t e;
                        e = q2.pop_front();
                        check("dut2 result channel", 32'(k), 32'(e.ch));
                        m_data2[k*8 +: 8] = e.d[7:0];
                        m_tmo2[k]         = e.t;
                        check("dut2 data word", {16'd0, data2}, {16'd0, m_data2});
                        check("dut2 tmo flags", {30'd0, tmo2}, {30'd0, m_tmo2});
                    end
                end
            end
        end
    end

    task automatic wait_trig1(input int ch, output int rise_cyc);
        bit seen;
        int w;
        seen     = 1'b0;
        rise_cyc = -1;
        for (int i = 0; i < SLOT + 50 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (trig[ch]) seen = 1'b1;
        end
        check("trig rise seen", 32'(seen), 32'd1);
        if (seen) begin
            rise_cyc = cyc;
            check("other trig low", {30'd0, trig & ~(2'b01 << ch)}, 32'd0);
            w = 0;
            while (trig[ch] && w < TRIGC + 20) begin
                w++;
                @(posedge clk);
                #1;
            end
            check("trig width", 32'(w), 32'(TRIGC));
        end
    endtask

    task automatic run_slot(input int ch, input int w, input logic [15:0] d, input logic t,
                            input int prev_rise, output int rise);
        wait_trig1(ch, rise);
        if (prev_rise >= 0) check("slot period", 32'(rise - prev_rise), 32'(SLOT));
        repeat (20) @(posedge clk);
        #1;
        q1.push_back(exp_t'{ch, d, t});
        if (w > 0) begin
            echo[ch] = 1'b1;
            repeat (w) @(posedge clk);
            #1;
            echo[ch] = 1'b0;
        end
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  r0, r1, c0, nt;
        bit  got;
        rst   = 1'b1;
        en    = 1'b0;
        en2   = 1'b0;
        echo  = '0;
        echo2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset trig", {30'd0, trig}, 32'd0);
        check("reset data", data, 32'd0);
        check("reset valid", {30'd0, valid}, 32'd0);
        check("reset tmo", {30'd0, tmo}, 32'd0);
        check("reset dut2 data", {16'd0, data2}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;
        en2 = 1'b1;

        fork
            begin
                bit seen2;
                seen2 = 1'b0;
                for (int i = 0; i < 100 && !seen2; i++) begin
                    @(posedge clk);
                    #1;
                    if (trig2[0]) seen2 = 1'b1;
                end
                check("dut2 trig rise seen", 32'(seen2), 32'd1);
                en2 = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                q2.push_back(exp_t'{0, 16'h0099, 1'b0});
                echo2[0] = 1'b1;
                repeat (150 * TICK) @(posedge clk);
                #1;
                echo2[0] = 1'b0;
            end
            begin
                run_slot(0, 20 * TICK,        16'h0020, 1'b0, -1, r0);
                run_slot(1, 300 * TICK + 3,   16'h0300, 1'b0, r0, r1);
                run_slot(0, TICK - 1,         16'h0000, 1'b0, r1, r0);
                run_slot(1, 10 * TICK,        16'h0010, 1'b0, r0, r1);
                run_slot(0, 0,                16'h9999, 1'b1, r1, r0);
                run_slot(1, 123 * TICK + 1,   16'h0123, 1'b0, r0, r1);
                run_slot(0, 57 * TICK + 2,    16'h0057, 1'b0, r1, r0);
            end
        join

        wait_trig1(1, r1);
        check("slot period", 32'(r1 - r0), 32'(SLOT));
        repeat (20) @(posedge clk);
        #1;
        echo[1] = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid-measure reset trig", {30'd0, trig}, 32'd0);
        check("mid-measure reset data", data, 32'd0);
        check("mid-measure reset valid", {30'd0, valid}, 32'd0);
        check("mid-measure reset tmo", {30'd0, tmo}, 32'd0);
        check("mid-measure reset dut2 data", {16'd0, data2}, 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        echo[1] = 1'b0;
        c0      = cyc;

        wait_trig1(0, r0);
        check("restart latency", 32'(r0 - c0), 32'd2);
        repeat (20) @(posedge clk);
        #1;
        q1.push_back(exp_t'{0, 16'h0003, 1'b0});
        echo[0] = 1'b1;
        repeat (3 * TICK) @(posedge clk);
        #1;
        echo[0] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk);
            #1;
            if (valid[0]) got = 1'b1;
        end
        check("final result strobe", 32'(got), 32'd1);
        en = 1'b0;
        nt = 0;
        repeat (2 * SLOT) begin
            @(posedge clk);
            #1;
            if (trig != 2'b00 || trig2 != 2'b00) nt++;
        end
        check("no trig after en low", 32'(nt), 32'd0);
        check("dut queue drained", 32'(q1.size()), 32'd0);
        check("dut2 queue drained", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
